maxpool_ctrl: RTL and testbench
===============================

Name: maxpool_ctrl

Overview:
- Sequencer for the max-pool pick datapath; one pooling pass per `start`.
- Walks every output window and every kernel element in row-major order, driving `pool_on`/`data_l`/`data_c` to the combinational pick block.
- Keeps a running unsigned maximum of the returned element and emits one pooled value per window over a valid/ready handshake.
- Sits between the layer controller (start/done) and the pooled-output buffer.

Parameters:
- datai_width, 4, input feature-map columns
- datai_height, 4, input feature-map rows
- kernel_width, 2, pooling window columns
- kernel_height, 2, pooling window rows
- stride, 2, window step in both directions
- padding, 0, border width applied by the pick block; indices are in padded coordinates
- datao_width, ((datai_width-kernel_width+2*padding)/stride)+1, output columns
- datao_height, ((datai_height-kernel_height+2*padding)/stride)+1, output rows
- bitwidth, 3, element width

Ports:
- clk_en  in  1  clock, rising edge
- reset_n  in  1  reset, asynchronous, active-high
- start  in  1  begin a pass; sampled only in IDLE
- pool_on  out  1  index outputs valid to pick block
- data_l  out  4  row index into padded map
- data_c  out  4  column index into padded map
- pick_data  in  bitwidth  element returned combinationally by pick block, same cycle
- out_valid  out  1  pooled value available
- out_ready  in  1  downstream accepts pooled value
- out_data  out  bitwidth  pooled maximum
- out_row  out  4  output row of out_data
- out_col  out  4  output column of out_data
- busy  out  1  high in SCAN/EMIT
- done  out  1  one-cycle pulse at end of pass

Behaviour:
- Reset (async, active-high):
  - state=IDLE; all counters, running max and outputs 0.
  - Reset asserted mid-pass aborts the pass immediately; no done pulse.
- Counters: orow (0..datao_height-1), ocol (0..datao_width-1), kr (0..kernel_height-1), kc (0..kernel_width-1). All 4 bits.
- Index generation:
  - data_l = orow*stride+kr; data_c = ocol*stride+kc.
  - Both must fit in 4 bits: (datao_height-1)*stride+kernel_height-1 <= 15, same for columns. Violating parameter sets are unsupported.
- IDLE:
  - pool_on=0, data_l=data_c=0, busy=0.
  - start=1 -> SCAN with all counters 0.
- SCAN (pool_on=1, busy=1), one kernel element per cycle:
  - (kr,kc)==(0,0): max <= pick_data.
  - Otherwise: max <= (pick_data > max) ? pick_data : max. Unsigned compare.
  - kc increments; on wrap it resets to 0 and kr increments.
  - On the last element (kr=kernel_height-1, kc=kernel_width-1): go to EMIT; out_data loads the final max, including that element; out_row/out_col load orow/ocol.
- EMIT (pool_on=0, busy=1, out_valid=1):
  - out_data/out_row/out_col stay stable while out_ready=0.
  - On out_valid & out_ready: ocol increments, wrapping to 0 with orow++.
  - Last window (orow=datao_height-1, ocol=datao_width-1) -> DONE; otherwise -> SCAN with kr=kc=0.
- DONE: done=1 for exactly one cycle, busy=0 -> IDLE. start in DONE is ignored.
- start outside IDLE is ignored; it does not restart the pass.
- out_valid deasserts the cycle after the handshake.
- Latency:
  - kernel_width*kernel_height SCAN cycles + 1 EMIT cycle per window, plus stall cycles.
  - Full pass with no stalls: datao_width*datao_height*(kw*kh+1) cycles after start, then done.
- out_ready is ignored outside EMIT.

Test Plan:
- Defaults; map element(r,c)=(r*4+c)%8 (rows 0123/4567/0123/4567); start one cycle, out_ready=1 -> outputs 5@(0,0), 7@(0,1), 5@(1,0), 7@(1,1). out_valid in cycles 5,10,15,20 after start; done pulse in cycle 21; busy low afterwards.
- Same stimulus; trace indices for window (1,1) -> (data_l,data_c) sequence (2,2),(2,3),(3,2),(3,3) with pool_on=1 only in those cycles.
- out_ready=0 for 3 cycles during the first EMIT -> out_valid, out_data=5, out_row=0, out_col=0 held; no index advance; next SCAN begins the cycle after out_ready=1; total pass 3 cycles longer.
- Window containing the first element as maximum (map all 0 except element(0,0)=7) -> first output 7, others 0. All elements 7 -> every output 7 (equal-value compare keeps max).
- Assert reset_n during SCAN of window 2 -> same-cycle async clear: pool_on=0, busy=0, out_valid=0, no done. New start -> full correct pass from window (0,0).
- Pulse start during SCAN and during EMIT -> ignored; exactly 4 outputs and one done per original start.

Source files
------------

// File: rtl/maxpool_ctrl.sv
// rtl/maxpool_ctrl.sv - max-pool sequencer: walks windows/kernel elements and emits pooled maxima
module maxpool_ctrl #(
    parameter int datai_width   = 4,
    parameter int datai_height  = 4,
    parameter int kernel_width  = 2,
    parameter int kernel_height = 2,
    parameter int stride        = 2,
    parameter int padding       = 0,
    parameter int datao_width   = ((datai_width - kernel_width + 2*padding) / stride) + 1,
    parameter int datao_height  = ((datai_height - kernel_height + 2*padding) / stride) + 1,
    parameter int bitwidth      = 3
) (
    input  logic                clk_en,
    input  logic                reset_n,
    input  logic                start,
    output logic                pool_on,
    output logic [3:0]          data_l,
    output logic [3:0]          data_c,
    input  logic [bitwidth-1:0] pick_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [bitwidth-1:0] out_data,
    output logic [3:0]          out_row,
    output logic [3:0]          out_col,
    output logic                busy,
    output logic                done
);

    localparam logic [3:0] KW_M1   = 4'(kernel_width - 1);
    localparam logic [3:0] KH_M1   = 4'(kernel_height - 1);
    localparam logic [3:0] OW_M1   = 4'(datao_width - 1);
    localparam logic [3:0] OH_M1   = 4'(datao_height - 1);
    localparam logic [3:0] STRIDE4 = 4'(stride);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_EMIT,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [3:0]          r_orow;
    logic [3:0]          r_ocol;
    logic [3:0]          r_kr;
    logic [3:0]          r_kc;
    logic [bitwidth-1:0] r_max;
    logic [bitwidth-1:0] r_out_data;
    logic [3:0]          r_out_row;
    logic [3:0]          r_out_col;

    logic                w_kc_last;
    logic                w_kr_last;
    logic                w_elem_last;
    logic                w_ocol_last;
    logic                w_orow_last;
    logic                w_first;
    logic [bitwidth-1:0] w_max_nxt;

    assign w_kc_last   = (r_kc == KW_M1);
    assign w_kr_last   = (r_kr == KH_M1);
    assign w_elem_last = w_kc_last && w_kr_last;
    assign w_ocol_last = (r_ocol == OW_M1);
    assign w_orow_last = (r_orow == OH_M1);
    assign w_first     = (r_kr == 4'd0) && (r_kc == 4'd0);

    // First element of a window seeds the max; ties keep the held value.
    assign w_max_nxt = (w_first || (pick_data > r_max)) ? pick_data : r_max;

    always_ff @(posedge clk_en or posedge reset_n) begin
        if (reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        pool_on     = 1'b0;
        data_l      = 4'd0;
        data_c      = 4'd0;
        out_valid   = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_SCAN;
                end
            end
            S_SCAN: begin
                pool_on = 1'b1;
                busy    = 1'b1;
                data_l  = r_orow * STRIDE4 + r_kr;
                data_c  = r_ocol * STRIDE4 + r_kc;
                if (w_elem_last) begin
                    w_state_nxt = S_EMIT;
                end
            end
            S_EMIT: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = (w_orow_last && w_ocol_last) ? S_DONE : S_SCAN;
                end
            end
            S_DONE: begin
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_en or posedge reset_n) begin
        if (reset_n) begin
            r_orow     <= 4'd0;
            r_ocol     <= 4'd0;
            r_kr       <= 4'd0;
            r_kc       <= 4'd0;
            r_max      <= '0;
            r_out_data <= '0;
            r_out_row  <= 4'd0;
            r_out_col  <= 4'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_orow <= 4'd0;
                        r_ocol <= 4'd0;
                        r_kr   <= 4'd0;
                        r_kc   <= 4'd0;
                    end
                end
                S_SCAN: begin
                    r_max <= w_max_nxt;
                    if (w_kc_last) begin
                        r_kc <= 4'd0;
                        r_kr <= w_kr_last ? 4'd0 : r_kr + 4'd1;
                    end else begin
                        r_kc <= r_kc + 4'd1;
                    end
                    if (w_elem_last) begin
                        r_out_data <= w_max_nxt;
                        r_out_row  <= r_orow;
                        r_out_col  <= r_ocol;
                    end
                end
                S_EMIT: begin
                    // Window counters wrap to zero after the last window, ready for the next pass.
                    if (out_ready) begin
                        if (w_ocol_last) begin
                            r_ocol <= 4'd0;
                            r_orow <= w_orow_last ? 4'd0 : r_orow + 4'd1;
                        end else begin
                            r_ocol <= r_ocol + 4'd1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign out_data = r_out_data;
    assign out_row  = r_out_row;
    assign out_col  = r_out_col;

endmodule

// File: tb/tb_maxpool_ctrl.sv
// tb/tb_maxpool_ctrl.sv - scoreboard bench for maxpool_ctrl with a behavioural pick block
module tb_maxpool_ctrl;

    logic       clk_en = 1'b0;
    logic       reset_n = 1'b1;
    logic       start = 1'b0;
    logic       pool_on;
    logic [3:0] data_l;
    logic [3:0] data_c;
    logic [2:0] pick_data;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [2:0] out_data;
    logic [3:0] out_row;
    logic [3:0] out_col;
    logic       busy;
    logic       done;

    logic [2:0] fmap [16][16];

    typedef struct {
        int d;
        int r;
        int c;
    } exp_t;
    exp_t sbq[$];

    int errs = 0;
    int checks = 0;

    maxpool_ctrl dut (
        .clk_en    (clk_en),
        .reset_n   (reset_n),
        .start     (start),
        .pool_on   (pool_on),
        .data_l    (data_l),
        .data_c    (data_c),
        .pick_data (pick_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_row   (out_row),
        .out_col   (out_col),
        .busy      (busy),
        .done      (done)
    );

    assign pick_data = fmap[data_l][data_c];

    always #5 clk_en = ~clk_en;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic load_map(input int kind);
        for (int r = 0; r < 16; r++) begin
            for (int c = 0; c < 16; c++) begin
                case (kind)
                    0: fmap[r][c] = 3'((r * 4 + c) % 8);
                    1: fmap[r][c] = (r == 0 && c == 0) ? 3'd7 : 3'd0;
                    default: fmap[r][c] = 3'd7;
                endcase
            end
        end
    endtask

    task automatic push_expected();
        exp_t e;
        for (int orow = 0; orow < 2; orow++) begin
            for (int ocol = 0; ocol < 2; ocol++) begin
                e.d = 0;
                for (int kr = 0; kr < 2; kr++)
                    for (int kc = 0; kc < 2; kc++)
                        if (int'(fmap[orow*2+kr][ocol*2+kc]) > e.d)
                            e.d = int'(fmap[orow*2+kr][ocol*2+kc]);
                e.r = orow;
                e.c = ocol;
                sbq.push_back(e);
            end
        end
    endtask

    task automatic run_pass(input int stall, input bit pulses, input int abort_at);
        int   n;
        int   n_out;
        int   n_done;
        int   done_cyc;
        int   vcyc[4];
        exp_t e;
        int   tl[4] = '{2, 2, 3, 3};
        int   tc[4] = '{2, 3, 2, 3};
        n_out = 0;
        n_done = 0;
        done_cyc = -1;
        push_expected();
        @(negedge clk_en);
        start = 1'b1;
        out_ready = 1'b1;
        @(posedge clk_en);
        #1;
        start = 1'b0;
        n = 1;
        while (n < 40) begin
            out_ready = !(n >= 5 && n < 5 + stall);
            start = pulses && (n == 2 || n == 5 || n == 21);
            if (n == abort_at) begin
                #2;
                reset_n = 1'b1;
                #1;
                check("abort_pool_on", pool_on, 0);
                check("abort_busy", busy, 0);
                check("abort_valid", out_valid, 0);
                check("abort_done", done, 0);
                @(posedge clk_en);
                #1;
                reset_n = 1'b0;
                sbq.delete();
                repeat (4) begin
                    @(negedge clk_en);
                    check("post_abort_done", done, 0);
                    check("post_abort_busy", busy, 0);
                end
                return;
            end
            @(negedge clk_en);
            if (out_valid && out_ready) begin
                if (sbq.size() == 0) begin
                    check("unexpected_output", 1, 0);
                end else begin
                    e = sbq.pop_front();
                    check("out_data", out_data, e.d);
                    check("out_row", out_row, e.r);
                    check("out_col", out_col, e.c);
                end
                if (n_out < 4) vcyc[n_out] = n;
                n_out++;
            end
            if (done) begin
                n_done++;
                done_cyc = n;
            end
            if (stall > 0 && n >= 5 && n < 5 + stall) begin
                check("stall_valid", out_valid, 1);
                check("stall_data", out_data, 5);
                check("stall_row", out_row, 0);
                check("stall_col", out_col, 0);
                check("stall_pool_on", pool_on, 0);
            end
            if (stall > 0 && n == 6 + stall) check("resume_pool_on", pool_on, 1);
            if (stall == 0 && n >= 16 && n <= 19) begin
                check("trace_pool_on", pool_on, 1);
                check("trace_l", data_l, tl[n-16]);
                check("trace_c", data_c, tc[n-16]);
            end
            if (stall == 0 && (n == 5 || n == 10 || n == 15 || n == 20 || n == 21))
                check("gap_pool_on", pool_on, 0);
            @(posedge clk_en);
            #1;
            n++;
        end
        start = 1'b0;
        out_ready = 1'b1;
        check("num_outputs", n_out, 4);
        check("num_done", n_done, 1);
        check("done_cycle", done_cyc, 21 + stall);
        check("busy_after", busy, 0);
        check("sb_empty", sbq.size(), 0);
        if (stall == 0 && !pulses && n_out == 4) begin
            check("valid_cyc0", vcyc[0], 5);
            check("valid_cyc1", vcyc[1], 10);
            check("valid_cyc2", vcyc[2], 15);
            check("valid_cyc3", vcyc[3], 20);
        end
    endtask

    initial begin
        load_map(0);
        repeat (2) @(posedge clk_en);
        #1;
        check("rst_pool_on", pool_on, 0);
        check("rst_busy", busy, 0);
        check("rst_valid", out_valid, 0);
        check("rst_done", done, 0);
        check("rst_data", out_data, 0);
        reset_n = 1'b0;
        @(negedge clk_en);
        check("idle_l", data_l, 0);
        check("idle_c", data_c, 0);
        check("idle_busy", busy, 0);

        run_pass(0, 1'b0, 0);
        run_pass(3, 1'b0, 0);
        load_map(1);
        run_pass(0, 1'b0, 0);
        load_map(2);
        run_pass(0, 1'b0, 0);
        load_map(0);
        run_pass(0, 1'b0, 11);
        run_pass(0, 1'b0, 0);
        run_pass(0, 1'b1, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
